// File: rtl/a_col_loader.sv
// A-matrix column loader: walks the A ROM one column at a time, unpacks two elements per
// ROM word into a full column and presents it over valid/ready. Optional: A_LOADER_LOOP_EN.
module a_col_loader #(
    parameter int DATA_W = 7,
    parameter int ROWS   = 8,
    parameter int COLS   = 4,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [2*DATA_W-1:0]      A_input,
    output logic [ROWS*DATA_W-1:0]   col_data,
    output logic [$clog2(COLS)-1:0]  col_idx,
    output logic                     col_valid,
    input  logic                     col_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int WORDS = ROWS / 2;
    localparam int IDX_W = $clog2(COLS);
    localparam int WK_W  = $clog2(WORDS);
    localparam int FC_W  = $clog2(WORDS + 1);
    localparam int WORD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT
    } state_t;

    state_t              state_q, state_d;
    logic [FC_W-1:0]     fc_q, fc_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [IDX_W-1:0]    col_idx_q, col_idx_d;
    logic                col_valid_q, col_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                last_col;
    logic                fetch_last;
    logic                loop_restart;
    logic [IDX_W-1:0]    idx_inc;
    logic [WK_W-1:0]     next_wk;

    // Streaming restart is only honoured when the loop option is built in.
`ifdef A_LOADER_LOOP_EN
    assign loop_restart = start;
`else
    assign loop_restart = 1'b0;
`endif

    assign last_col   = (col_idx_q == IDX_W'(COLS - 1));
    assign fetch_last = (fc_q == FC_W'(WORDS));
    assign idx_inc    = col_idx_q + IDX_W'(1);

    // fc_q counts edges since the column fetch began; the address runs one word ahead of it
    // and parks on the last word once all words have been issued.
    always_comb begin
        if (fc_q >= FC_W'(WORDS - 1)) begin
            next_wk = WK_W'(WORDS - 1);
        end else begin
            next_wk = WK_W'(fc_q + FC_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fc_q        <= '0;
            rom_addr_q  <= '0;
            col_idx_q   <= '0;
            col_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fc_q        <= fc_d;
            rom_addr_q  <= rom_addr_d;
            col_idx_q   <= col_idx_d;
            col_valid_q <= col_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_last) begin
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (col_ready) begin
                    if (!last_col || loop_restart) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fc_d        = fc_q;
        rom_addr_d  = rom_addr_q;
        col_idx_d   = col_idx_q;
        col_valid_d = col_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fc_d       = '0;
                    rom_addr_d = '0;
                    col_idx_d  = '0;
                    busy_d     = 1'b1;
                end
            end
            S_FETCH: begin
                rom_addr_d = {col_idx_q, next_wk};
                if (fetch_last) begin
                    col_valid_d = 1'b1;
                end else begin
                    fc_d = fc_q + FC_W'(1);
                end
            end
            S_PRESENT: begin
                if (col_ready) begin
                    col_valid_d = 1'b0;
                    fc_d        = '0;
                    if (!last_col) begin
                        col_idx_d  = idx_inc;
                        rom_addr_d = {idx_inc, {WK_W{1'b0}}};
                    end else begin
                        done_d = 1'b1;
                        if (loop_restart) begin
                            col_idx_d  = '0;
                            rom_addr_d = '0;
                        end else begin
                            busy_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                col_valid_d = 1'b0;
            end
        endcase
    end

    // Word k lands two edges after its address, i.e. when fc_q == k+1; each word fills
    // two adjacent rows, row 1 at the top of col_data.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            logic [WORD_W-1:0] word_q, word_d;

            always_comb begin
                word_d = word_q;
                if (state_q == S_FETCH && fc_q == FC_W'(gi + 1)) begin
                    word_d = A_input;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign col_data[ROWS*DATA_W-1-gi*WORD_W -: WORD_W] = word_q;
        end
    endgenerate

    assign rom_addr  = rom_addr_q;
    assign col_idx   = col_idx_q;
    assign col_valid = col_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_a_col_loader.sv
// Scoreboard bench for a_col_loader: ROM model, cycle-level expectation model and a monitor.
module tb_a_col_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  rom_addr;
    logic [13:0] A_input;
    logic [55:0] col_data;
    logic [1:0]  col_idx;
    logic        col_valid;
    logic        col_ready;
    logic        busy;
    logic        done;

    a_col_loader #(.DATA_W(7), .ROWS(8), .COLS(4), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .A_input(A_input),
        .col_data(col_data), .col_idx(col_idx), .col_valid(col_valid),
        .col_ready(col_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

`ifdef A_LOADER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    // ROM: 16 words, registered read
    logic [13:0] mem [16];
    logic [13:0] rom_q = '0;
    always @(posedge clk) rom_q <= mem[rom_addr];
    assign A_input = rom_q;

    typedef struct packed {
        logic [1:0]  idx;
        logic [55:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    // Element at 1-based row r of column c, from the packing rule of the ROM words.
    function automatic logic [55:0] col_of(input int c);
        logic [55:0] v;
        logic [13:0] w;
        v = '0;
        for (int r = 1; r <= 8; r++) begin
            w = mem[c * 4 + (r - 1) / 2];
            v[(8 - r) * 7 +: 7] = ((r - 1) % 2 == 0) ? w[13:7] : w[6:0];
        end
        return v;
    endfunction

    function automatic void push_all();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            e.idx  = 2'(c);
            e.data = col_of(c);
            exp_q.push_back(e);
        end
    endfunction

    // Expected outputs after each edge, derived only from inputs and timing rules.
    bit armed = 0;
    bit m_busy = 0, m_done = 0, m_valid = 0, m_fresh = 0;
    int m_col = 0, m_t = 0, m_addr = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_valid <= 0; m_fresh <= 1;
            m_col <= 0; m_t <= 0; m_addr <= 0; armed <= 1;
            exp_q.delete();
        end else begin
            m_done <= 0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1; m_col <= 0; m_t <= 0; m_addr <= 0; m_fresh <= 0;
                    push_all();
                end
            end else if (!m_valid) begin
                m_t    <= m_t + 1;
                m_addr <= m_col * 4 + ((m_t + 1 > 3) ? 3 : m_t + 1);
                if (m_t + 1 == 5) m_valid <= 1;
            end else if (col_ready) begin
                m_valid <= 0;
                if (m_col < 3) begin
                    m_col <= m_col + 1; m_t <= 0; m_addr <= (m_col + 1) * 4;
                end else begin
                    m_done <= 1;
                    if (LOOP && start) begin
                        m_col <= 0; m_t <= 0; m_addr <= 0;
                        push_all();
                    end else begin
                        m_busy <= 0;
                    end
                end
            end
        end
    end

    // Monitor: compares on the falling edge, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            chk("rom_addr", rom_addr, m_addr);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("col_valid", col_valid, m_valid);
            if (m_fresh) chk("col_data_reset", col_data, 0);
            if (col_valid && m_valid) begin
                chk("col_idx", col_idx, m_col);
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", 0, 1);
                end else begin
                    e = exp_q[0];
                    chk("col_data", col_data, e.data);
                    chk("col_idx_sb", col_idx, e.idx);
                    if (col_ready && !rst) begin
                        void'(exp_q.pop_front());
                        $display("accept col %0d data %014h", col_idx, col_data);
                    end
                end
            end
        end
    end

    task automatic run_xfer(input int ready_mode, input bit spam_start);
        bit finished;
        int stall;
        finished = 0;
        stall = 0;
        start = 1;
        col_ready = (ready_mode != 2);
        @(posedge clk); #1;
        start = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!busy) begin
                finished = 1;
                break;
            end
            case (ready_mode)
                1: begin
                    if (col_valid && col_idx == 2'd2 && stall < 10) begin
                        col_ready = 0;
                        stall++;
                    end else begin
                        col_ready = 1;
                    end
                end
                2: col_ready = 1'($urandom_range(0, 1));
                default: col_ready = 1;
            endcase
            if (spam_start) start = (col_idx != 2'd3) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        start = 0;
        col_ready = 0;
        if (!finished) chk("xfer_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid_idx(input logic [1:0] idx);
        bit hit;
        hit = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (col_valid && col_idx == idx) begin
                hit = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!hit) chk("wait_valid_timeout", 0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int w = 0; w < 16; w++) begin
            if (w < 4) mem[w] = {7'(2 * w + 1), 7'(2 * w + 2)};
            else       mem[w] = {7'd1, 7'd1};
        end
        rst = 1; start = 0; col_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (2) @(posedge clk);
        #1;

        // Straight run with the consumer always ready, then a long stall on column 2.
        run_xfer(0, 0);
        run_xfer(1, 0);
        // Start requests while busy must not launch extra transfers.
        run_xfer(0, 1);

        // Reset three edges into the fetch of column 1, then a clean transfer.
        start = 1; col_ready = 1;
        @(posedge clk); #1;
        start = 0;
        wait_valid_idx(2'd0);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0; col_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        run_xfer(0, 0);

`ifdef A_LOADER_LOOP_EN
        // Hold start through the final accept to stream a second pass, then let go.
        start = 1; col_ready = 1;
        @(posedge clk); #1;
        wait_valid_idx(2'd3);
        @(posedge clk); #1;
        wait_valid_idx(2'd0);
        wait_valid_idx(2'd3);
        start = 0;
        for (int cyc = 0; cyc < 20 && busy; cyc++) begin
            @(posedge clk); #1;
        end
        col_ready = 0;
        repeat (2) @(posedge clk);
        #1;
`endif

        // Random ROM contents, random back-pressure and stray start requests.
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < 16; w++) mem[w] = 14'($urandom);
            run_xfer(2, (it % 2) == 1);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
